player_proj_handler: RTL and testbench

PLAYER_PROJ_HANDLER -- requirements
Module: player_proj_handler

---
 rtl/player_proj_handler.sv | 171 +++++++++++++++++
 tb/tb_player_proj_handler.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_proj_handler.sv
// player_proj_handler
//   Manages up to three player projectiles. A rising edge on the shoot button
//   fires a projectile into the lowest free slot when the cooldown is idle.
//   Each projectile moves up by STEP pixels per speed pulse and leaves when it
//   passes the top of the screen. On overlap with the boss box it is removed,
//   and bossHit / hitMask pulse for one cycle.
//
// Ports
//   clk          system clock, all state on rising edge
//   sw           asynchronous active-low reset
//   pulse_speed  one-cycle movement tick
//   shoot        debounced shoot button level
//   playerX/Y/W  player left edge, top edge, width
//   bossX/Y/W/H  boss bounding box
//   projNX/NY    slot N position, 0 while slot N is inactive
//   projActive   per-slot active flags, bit0 = slot 1
//   bossHit      one-cycle pulse on any boss collision
//   hitMask      slots that collided, valid with bossHit
module player_proj_handler #(
    parameter int unsigned PROJ_W   = 4,
    parameter int unsigned PROJ_H   = 10,
    parameter int unsigned STEP     = 2,
    parameter int unsigned COOLDOWN = 20
) (
    input  logic       clk,
    input  logic       sw,
    input  logic       pulse_speed,
    input  logic       shoot,
    input  logic [9:0] playerX,
    input  logic [8:0] playerY,
    input  logic [9:0] playerW,
    input  logic [9:0] bossX,
    input  logic [8:0] bossY,
    input  logic [9:0] bossW,
    input  logic [8:0] bossH,
    output logic [9:0] proj1X,
    output logic [9:0] proj2X,
    output logic [9:0] proj3X,
    output logic [8:0] proj1Y,
    output logic [8:0] proj2Y,
    output logic [8:0] proj3Y,
    output logic [2:0] projActive,
    output logic       bossHit,
    output logic [2:0] hitMask
);

    localparam logic [9:0]  ProjWHalf = 10'(PROJ_W / 2);
    localparam logic [10:0] ProjW11   = 11'(PROJ_W);
    localparam logic [10:0] ProjH11   = 11'(PROJ_H);
    localparam logic [8:0]  ProjH9    = 9'(PROJ_H);
    localparam logic [8:0]  Step9     = 9'(STEP);
    localparam logic [7:0]  Cooldown8 = 8'(COOLDOWN);

    logic [2:0]       activeQ, activeD;
    logic [2:0][9:0]  xQ, xD;
    logic [2:0][8:0]  yQ, yD;
    logic [7:0]       cooldownQ, cooldownD;
    logic             shootPrevQ;
    // Low for the first cycle after reset so a button held through reset
    // is not mistaken for a fresh press.
    logic             prevValidQ;
    logic             bossHitQ;
    logic [2:0]       hitMaskQ;

    logic [2:0]       collide;
    logic             shootRise;
    logic             shotOk;
    logic [1:0]       spawnIdx;
    logic [9:0]       spawnX;
    logic [8:0]       spawnY;

    // Collision uses 11-bit sums so box edges near 1023/511 cannot wrap.
    always_comb begin
        collide = 3'b000;
        for (int i = 0; i < 3; i++) begin
            collide[i] = activeQ[i]
                && ({1'b0, xQ[i]} < ({1'b0, bossX} + {1'b0, bossW}))
                && (({1'b0, xQ[i]} + ProjW11) > {1'b0, bossX})
                && ({2'b00, yQ[i]} < ({2'b00, bossY} + {2'b00, bossH}))
                && (({2'b00, yQ[i]} + ProjH11) > {2'b00, bossY});
        end
    end

    always_comb begin
        shootRise = shoot & ~shootPrevQ & prevValidQ;
        // Full check uses start-of-cycle flags: a slot freed this cycle
        // cannot take a spawn until the next one.
        shotOk    = shootRise && (cooldownQ == 8'd0) && (activeQ != 3'b111);

        if (!activeQ[0]) begin
            spawnIdx = 2'd0;
        end else if (!activeQ[1]) begin
            spawnIdx = 2'd1;
        end else begin
            spawnIdx = 2'd2;
        end

        spawnX = playerX + (playerW >> 1) - ProjWHalf;
        spawnY = (playerY < ProjH9) ? 9'd0 : playerY - ProjH9;

        activeD = activeQ;
        xD      = xQ;
        yD      = yQ;

        for (int i = 0; i < 3; i++) begin
            if (collide[i]) begin
                // Collision wins over movement.
                activeD[i] = 1'b0;
                xD[i]      = 10'd0;
                yD[i]      = 9'd0;
            end else if (activeQ[i] && pulse_speed) begin
                if (yQ[i] >= Step9) begin
                    yD[i] = yQ[i] - Step9;
                end else begin
                    activeD[i] = 1'b0;
                    xD[i]      = 10'd0;
                    yD[i]      = 9'd0;
                end
            end

            // Spawn target is always a slot that was inactive, so it never
            // collides with the update above.
            if (shotOk && (spawnIdx == 2'(i))) begin
                activeD[i] = 1'b1;
                xD[i]      = spawnX;
                yD[i]      = spawnY;
            end
        end

        if (shotOk) begin
            cooldownD = Cooldown8;
        end else if (pulse_speed && (cooldownQ != 8'd0)) begin
            cooldownD = cooldownQ - 8'd1;
        end else begin
            cooldownD = cooldownQ;
        end
    end

    always_ff @(posedge clk or negedge sw) begin
        if (!sw) begin
            activeQ    <= 3'b000;
            xQ         <= '0;
            yQ         <= '0;
            cooldownQ  <= 8'd0;
            shootPrevQ <= 1'b0;
            prevValidQ <= 1'b0;
            bossHitQ   <= 1'b0;
            hitMaskQ   <= 3'b000;
        end else begin
            activeQ    <= activeD;
            xQ         <= xD;
            yQ         <= yD;
            cooldownQ  <= cooldownD;
            shootPrevQ <= shoot;
            prevValidQ <= 1'b1;
            bossHitQ   <= |collide;
            hitMaskQ   <= collide;
        end
    end

    assign proj1X     = xQ[0];
    assign proj2X     = xQ[1];
    assign proj3X     = xQ[2];
    assign proj1Y     = yQ[0];
    assign proj2Y     = yQ[1];
    assign proj3Y     = yQ[2];
    assign projActive = activeQ;
    assign bossHit    = bossHitQ;
    assign hitMask    = hitMaskQ;

endmodule

// File: tb/tb_player_proj_handler.sv
// Bench for player_proj_handler. Spawn coordinates and hit masks are pushed
// to queues when the stimulus is driven and popped when the DUT responds.
module tb_player_proj_handler;

    logic       clk;
    logic       sw;
    logic       pulse_speed;
    logic       shoot;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic [9:0] playerW;
    logic [9:0] bossX;
    logic [8:0] bossY;
    logic [9:0] bossW;
    logic [8:0] bossH;
    logic [9:0] proj1X, proj2X, proj3X;
    logic [8:0] proj1Y, proj2Y, proj3Y;
    logic [2:0] projActive;
    logic       bossHit;
    logic [2:0] hitMask;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         slot;
        logic [9:0] x;
        logic [8:0] y;
    } spawnT;

    spawnT      spawnQ[$];
    logic [2:0] hitQ[$];

    player_proj_handler dut (
        .clk         (clk),
        .sw          (sw),
        .pulse_speed (pulse_speed),
        .shoot       (shoot),
        .playerX     (playerX),
        .playerY     (playerY),
        .playerW     (playerW),
        .bossX       (bossX),
        .bossY       (bossY),
        .bossW       (bossW),
        .bossH       (bossH),
        .proj1X      (proj1X),
        .proj2X      (proj2X),
        .proj3X      (proj3X),
        .proj1Y      (proj1Y),
        .proj2Y      (proj2Y),
        .proj3Y      (proj3Y),
        .projActive  (projActive),
        .bossHit     (bossHit),
        .hitMask     (hitMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every bossHit pulse must match a pending expected hit mask.
    always @(negedge clk) begin
        if (sw && bossHit) begin
            checks++;
            if (hitQ.size() == 0) begin
                errors++;
                $display("FAIL hit_unexpected: bossHit=1 hitMask=%b, no hit expected", hitMask);
            end else begin
                logic [2:0] expMask;
                expMask = hitQ.pop_front();
                if (hitMask !== expMask) begin
                    errors++;
                    $display("FAIL hit_mask: got %b, want %b", hitMask, expMask);
                end
            end
        end
    end

    function automatic logic [9:0] slotX(int s);
        return (s == 0) ? proj1X : (s == 1) ? proj2X : proj3X;
    endfunction

    function automatic logic [8:0] slotY(int s);
        return (s == 0) ? proj1Y : (s == 1) ? proj2Y : proj3Y;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(int n = 1);
        repeat (n) begin
            pulse_speed = 1'b1;
            tick();
            pulse_speed = 1'b0;
        end
    endtask

    // Low cycle, then high cycle; returns just after the edge that sees the rise.
    task automatic shootEdge();
        shoot = 1'b0;
        tick();
        shoot = 1'b1;
        tick();
        shoot = 1'b0;
    endtask

    task automatic doReset();
        #2;
        sw = 1'b0;
        #2;
        sw = 1'b1;
        tick(2);
    endtask

    task automatic noBoss();
        bossX = 10'd0;
        bossY = 9'd0;
        bossW = 10'd0;
        bossH = 9'd0;
    endtask

    task automatic test_reset();
        spawnT e;
        sw = 1'b0;
        #1;
        checks++;
        if ({projActive, proj1X, proj2X, proj3X, proj1Y, proj2Y, proj3Y, bossHit, hitMask} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: projActive=%b bossHit=%b hitMask=%b, want all 0",
                     projActive, bossHit, hitMask);
        end
        #3;
        sw = 1'b1;
        tick(2);
        // Nothing fires without a shoot edge.
        checks++;
        if (projActive !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: projActive=%b want 000", projActive);
        end
    endtask

    task automatic test_spawn();
        spawnT e;
        noBoss();
        playerX = 10'd244;
        playerY = 9'd331;
        playerW = 10'd40;
        spawnQ.push_back('{0, 10'd262, 9'd321});
        shootEdge();
        e = spawnQ.pop_front();
        checks++;
        if (projActive !== 3'b001 || slotX(e.slot) !== e.x || slotY(e.slot) !== e.y) begin
            errors++;
            $display("FAIL spawn: active=%b x=%0d y=%0d, want 001 x=%0d y=%0d",
                     projActive, slotX(e.slot), slotY(e.slot), e.x, e.y);
        end
        pulse();
        checks++;
        if (proj1Y !== 9'd319) begin
            errors++;
            $display("FAIL first_move: proj1Y=%0d want 319", proj1Y);
        end
    endtask

    task automatic test_exit();
        pulse(159);
        checks++;
        if (proj1Y !== 9'd1 || projActive !== 3'b001) begin
            errors++;
            $display("FAIL exit_last: proj1Y=%0d active=%b want 1 001", proj1Y, projActive);
        end
        pulse();
        checks++;
        if (projActive !== 3'b000 || proj1X !== 10'd0 || proj1Y !== 9'd0) begin
            errors++;
            $display("FAIL exit_gone: active=%b x=%0d y=%0d want 000 0 0",
                     projActive, proj1X, proj1Y);
        end
    endtask

    task automatic test_hit();
        spawnT e;
        doReset();
        bossX = 10'd250;
        bossY = 9'd50;
        bossW = 10'd80;
        bossH = 9'd60;
        playerX = 10'd244;
        playerY = 9'd331;
        spawnQ.push_back('{0, 10'd262, 9'd321});
        shootEdge();
        e = spawnQ.pop_front();
        checks++;
        if (slotX(e.slot) !== e.x || slotY(e.slot) !== e.y) begin
            errors++;
            $display("FAIL hit_spawn: x=%0d y=%0d want %0d %0d",
                     slotX(e.slot), slotY(e.slot), e.x, e.y);
        end
        pulse(106);
        checks++;
        if (proj1Y !== 9'd109 || bossHit !== 1'b0 || projActive !== 3'b001) begin
            errors++;
            $display("FAIL hit_pre: y=%0d bossHit=%b active=%b want 109 0 001",
                     proj1Y, bossHit, projActive);
        end
        hitQ.push_back(3'b001);
        tick();
        checks++;
        if (bossHit !== 1'b1 || hitMask !== 3'b001 || projActive !== 3'b000) begin
            errors++;
            $display("FAIL hit_pulse: bossHit=%b mask=%b active=%b want 1 001 000",
                     bossHit, hitMask, projActive);
        end
        tick();
        checks++;
        if (bossHit !== 1'b0) begin
            errors++;
            $display("FAIL hit_one_cycle: bossHit=%b want 0", bossHit);
        end
    endtask

    task automatic test_full();
        spawnT e;
        doReset();
        noBoss();
        playerY = 9'd331;
        for (int k = 0; k < 3; k++) begin
            playerX = (k == 0) ? 10'd244 : (k == 1) ? 10'd100 : 10'd500;
            spawnQ.push_back('{k, (k == 0) ? 10'd262 : (k == 1) ? 10'd118 : 10'd518, 9'd321});
            shootEdge();
            e = spawnQ.pop_front();
            checks++;
            if (slotX(e.slot) !== e.x || slotY(e.slot) !== e.y) begin
                errors++;
                $display("FAIL full_spawn%0d: x=%0d y=%0d want %0d %0d",
                         k, slotX(e.slot), slotY(e.slot), e.x, e.y);
            end
            pulse(25);
        end
        playerX = 10'd10;
        shootEdge();
        checks++;
        if (projActive !== 3'b111 || proj3X !== 10'd518 || proj3Y !== 9'd271
            || proj1Y !== 9'd171) begin
            errors++;
            $display("FAIL full_drop: active=%b p3=(%0d,%0d) p1y=%0d want 111 (518,271) 171",
                     projActive, proj3X, proj3Y, proj1Y);
        end
    endtask

    task automatic test_cooldown();
        spawnT e;
        doReset();
        noBoss();
        playerX = 10'd244;
        playerY = 9'd331;
        shootEdge();
        pulse(5);
        shootEdge();
        checks++;
        if (projActive !== 3'b001) begin
            errors++;
            $display("FAIL cooldown_5: active=%b want 001", projActive);
        end
        pulse(14);
        shootEdge();
        checks++;
        if (projActive !== 3'b001) begin
            errors++;
            $display("FAIL cooldown_19: active=%b want 001", projActive);
        end
        pulse();
        spawnQ.push_back('{1, 10'd262, 9'd321});
        shootEdge();
        e = spawnQ.pop_front();
        checks++;
        if (projActive !== 3'b011 || slotX(e.slot) !== e.x || slotY(e.slot) !== e.y) begin
            errors++;
            $display("FAIL cooldown_20: active=%b x=%0d y=%0d want 011 %0d %0d",
                     projActive, slotX(e.slot), slotY(e.slot), e.x, e.y);
        end
    endtask

    task automatic test_top_clamp();
        spawnT e;
        doReset();
        noBoss();
        playerX = 10'd244;
        playerY = 9'd5;
        spawnQ.push_back('{0, 10'd262, 9'd0});
        shootEdge();
        e = spawnQ.pop_front();
        checks++;
        if (projActive !== 3'b001 || slotX(e.slot) !== e.x || slotY(e.slot) !== e.y) begin
            errors++;
            $display("FAIL clamp_spawn: active=%b x=%0d y=%0d want 001 %0d %0d",
                     projActive, slotX(e.slot), slotY(e.slot), e.x, e.y);
        end
        pulse();
        checks++;
        if (projActive !== 3'b000 || proj1Y !== 9'd0) begin
            errors++;
            $display("FAIL clamp_exit: active=%b y=%0d want 000 0", projActive, proj1Y);
        end
        playerY = 9'd331;
    endtask

    task automatic test_simultaneous();
        doReset();
        noBoss();
        playerY = 9'd331;
        playerX = 10'd100;
        shootEdge();
        pulse(20);
        shootEdge();
        pulse(20);
        playerX = 10'd500;
        shootEdge();
        pulse(20);
        checks++;
        if (projActive !== 3'b111 || proj1Y !== 9'd201 || proj2Y !== 9'd241
            || proj3Y !== 9'd281) begin
            errors++;
            $display("FAIL simul_setup: active=%b y=%0d,%0d,%0d want 111 201,241,281",
                     projActive, proj1Y, proj2Y, proj3Y);
        end
        shoot = 1'b0;
        tick();
        bossX = 10'd100;
        bossW = 10'd50;
        bossY = 9'd150;
        bossH = 9'd200;
        shoot = 1'b1;
        hitQ.push_back(3'b011);
        tick();
        shoot = 1'b0;
        noBoss();
        checks++;
        if (bossHit !== 1'b1 || hitMask !== 3'b011 || projActive !== 3'b100
            || proj3X !== 10'd518 || proj3Y !== 9'd281) begin
            errors++;
            $display("FAIL simul_hit: bossHit=%b mask=%b active=%b p3=(%0d,%0d)",
                     bossHit, hitMask, projActive, proj3X, proj3Y);
        end
        tick();
        checks++;
        if (bossHit !== 1'b0 || projActive !== 3'b100) begin
            errors++;
            $display("FAIL simul_after: bossHit=%b active=%b want 0 100", bossHit, projActive);
        end
    endtask

    task automatic test_reset_midflight();
        spawnT e;
        doReset();
        noBoss();
        playerX = 10'd244;
        playerY = 9'd331;
        shootEdge();
        pulse(20);
        shootEdge();
        pulse();
        checks++;
        if (projActive !== 3'b011) begin
            errors++;
            $display("FAIL mid_setup: active=%b want 011", projActive);
        end
        #2;
        sw = 1'b0;
        #1;
        checks++;
        if ({projActive, proj1X, proj2X, proj3X, proj1Y, proj2Y, proj3Y, bossHit, hitMask} !== '0)
        begin
            errors++;
            $display("FAIL mid_reset: active=%b p1=(%0d,%0d) p2=(%0d,%0d) want all 0",
                     projActive, proj1X, proj1Y, proj2X, proj2Y);
        end
        shoot = 1'b1;
        #3;
        sw = 1'b1;
        tick(3);
        checks++;
        if (projActive !== 3'b000) begin
            errors++;
            $display("FAIL held_shoot: active=%b want 000", projActive);
        end
        spawnQ.push_back('{0, 10'd262, 9'd321});
        shootEdge();
        e = spawnQ.pop_front();
        checks++;
        if (projActive !== 3'b001 || slotX(e.slot) !== e.x || slotY(e.slot) !== e.y) begin
            errors++;
            $display("FAIL rearm_shot: active=%b x=%0d y=%0d want 001 %0d %0d",
                     projActive, slotX(e.slot), slotY(e.slot), e.x, e.y);
        end
    endtask

    initial begin
        sw = 1'b0;
        pulse_speed = 1'b0;
        shoot = 1'b0;
        playerX = 10'd0;
        playerY = 9'd0;
        playerW = 10'd40;
        noBoss();
        #2;
        test_reset();
        test_spawn();
        test_exit();
        test_hit();
        test_full();
        test_cooldown();
        test_top_clamp();
        test_simultaneous();
        test_reset_midflight();
        tick(2);
        checks++;
        if (hitQ.size() != 0) begin
            errors++;
            $display("FAIL hit_missing: %0d expected bossHit pulses never seen", hitQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
